// File: rtl/ring_sched_pkg.sv
// Shared types and defaults for the two-channel slot-ring scheduler.
package ring_sched_pkg;

    localparam int unsigned SLOT_AW_DEFAULT = 2;
    localparam int unsigned PTR_W_DEFAULT   = SLOT_AW_DEFAULT + 1;
    localparam int unsigned NUM_CH          = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

endpackage

// File: rtl/ring_sched_ring_ptr.sv
// One channel's slot ring: write/read pointers with wrap bit, full/empty flags
// and sticky overflow on a commit into a full ring.
module ring_ptr
    import ring_sched_pkg::*;
#(
    parameter int unsigned SLOT_AW = SLOT_AW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_commit,
    input  logic             i_release,
    output logic [SLOT_AW:0] o_wr_ptr,
    output logic [SLOT_AW:0] o_rd_ptr,
    output logic             o_not_full,
    output logic             o_not_empty,
    output logic             o_ovf
);

    localparam int unsigned PTR_W = SLOT_AW + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_ovf;
    logic             w_full;
    logic             w_wr_inc;

    // Full when the wrap bits differ but the slot addresses coincide.
    assign w_full   = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                      (r_wr_ptr[SLOT_AW-1:0] == r_rd_ptr[SLOT_AW-1:0]);
    assign w_wr_inc = i_commit && !w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_inc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_commit && w_full) begin
                r_ovf <= 1'b1;
            end
            if (i_release) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    assign o_wr_ptr    = r_wr_ptr;
    assign o_rd_ptr    = r_rd_ptr;
    assign o_not_full  = !w_full;
    assign o_not_empty = (r_wr_ptr != r_rd_ptr);
    assign o_ovf       = r_ovf;

endmodule

// File: rtl/ring_sched.sv
// Two-ring slot controller with round-robin egress scheduling over a
// req/ack/done handshake; one slot is in flight at a time.
module ring_sched
    import ring_sched_pkg::*;
#(
    parameter int unsigned SLOT_AW = SLOT_AW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_commit_0,
    input  logic               wr_commit_1,
    output logic [SLOT_AW:0]   wr_ptr_0,
    output logic [SLOT_AW:0]   wr_ptr_1,
    output logic               wr_greenflag_0,
    output logic               wr_greenflag_1,
    output logic [SLOT_AW:0]   rd_ptr_0,
    output logic [SLOT_AW:0]   rd_ptr_1,
    output logic               rd_greenflag_0,
    output logic               rd_greenflag_1,
    output logic               tx_req,
    output logic               tx_ch,
    output logic [SLOT_AW-1:0] tx_slot,
    input  logic               tx_ack,
    input  logic               tx_done,
    output logic               ovf_0,
    output logic               ovf_1,
    output logic               busy
);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_tx_ch;
    logic [SLOT_AW-1:0] r_tx_slot;
    logic               r_last_ch;

    logic               w_any_ready;
    logic               w_grant_ch;
    logic [SLOT_AW-1:0] w_grant_slot;
    logic               w_release_0;
    logic               w_release_1;
    logic               w_tx_req;
    logic               w_busy;

    ring_ptr #(.SLOT_AW(SLOT_AW)) u_ring_0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_commit    (wr_commit_0),
        .i_release   (w_release_0),
        .o_wr_ptr    (wr_ptr_0),
        .o_rd_ptr    (rd_ptr_0),
        .o_not_full  (wr_greenflag_0),
        .o_not_empty (rd_greenflag_0),
        .o_ovf       (ovf_0)
    );

    ring_ptr #(.SLOT_AW(SLOT_AW)) u_ring_1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_commit    (wr_commit_1),
        .i_release   (w_release_1),
        .o_wr_ptr    (wr_ptr_1),
        .o_rd_ptr    (rd_ptr_1),
        .o_not_full  (wr_greenflag_1),
        .o_not_empty (rd_greenflag_1),
        .o_ovf       (ovf_1)
    );

    // On a tie the channel that did not win last time is served.
    assign w_any_ready  = rd_greenflag_0 || rd_greenflag_1;
    assign w_grant_ch   = (rd_greenflag_0 && rd_greenflag_1) ? !r_last_ch : rd_greenflag_1;
    assign w_grant_slot = w_grant_ch ? rd_ptr_1[SLOT_AW-1:0] : rd_ptr_0[SLOT_AW-1:0];

    assign w_release_0 = (r_state == ST_XFER) && tx_done && !r_tx_ch;
    assign w_release_1 = (r_state == ST_XFER) && tx_done &&  r_tx_ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any_ready) w_next_state = ST_REQ;
            ST_REQ:  if (tx_ack)      w_next_state = ST_XFER;
            ST_XFER: if (tx_done)     w_next_state = ST_IDLE;
            default:                  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tx_req = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            ST_REQ: begin
                w_tx_req = 1'b1;
                w_busy   = 1'b1;
            end
            ST_XFER: w_busy = 1'b1;
            default: begin
                w_tx_req = 1'b0;
                w_busy   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_ch   <= 1'b0;
            r_tx_slot <= '0;
            r_last_ch <= 1'b1;
        end else if ((r_state == ST_IDLE) && w_any_ready) begin
            r_tx_ch   <= w_grant_ch;
            r_tx_slot <= w_grant_slot;
            r_last_ch <= w_grant_ch;
        end
    end

    assign tx_req  = w_tx_req;
    assign busy    = w_busy;
    assign tx_ch   = r_tx_ch;
    assign tx_slot = r_tx_slot;

endmodule

// File: tb/tb_ring_sched.sv
// Self-checking bench for ring_sched: occupancy-count reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_ring_sched;

    localparam int unsigned AW    = 2;
    localparam int          DEPTH = 4;
    localparam int          PMOD  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_commit_0 = 1'b0;
    logic          wr_commit_1 = 1'b0;
    logic [AW:0]   wr_ptr_0, wr_ptr_1, rd_ptr_0, rd_ptr_1;
    logic          wr_greenflag_0, wr_greenflag_1, rd_greenflag_0, rd_greenflag_1;
    logic          tx_req, tx_ch, busy, ovf_0, ovf_1;
    logic [AW-1:0] tx_slot;
    logic          tx_ack = 1'b0;
    logic          tx_done = 1'b0;

    always #5 clk = ~clk;

    ring_sched #(.SLOT_AW(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_commit_0    (wr_commit_0),
        .wr_commit_1    (wr_commit_1),
        .wr_ptr_0       (wr_ptr_0),
        .wr_ptr_1       (wr_ptr_1),
        .wr_greenflag_0 (wr_greenflag_0),
        .wr_greenflag_1 (wr_greenflag_1),
        .rd_ptr_0       (rd_ptr_0),
        .rd_ptr_1       (rd_ptr_1),
        .rd_greenflag_0 (rd_greenflag_0),
        .rd_greenflag_1 (rd_greenflag_1),
        .tx_req         (tx_req),
        .tx_ch          (tx_ch),
        .tx_slot        (tx_slot),
        .tx_ack         (tx_ack),
        .tx_done        (tx_done),
        .ovf_0          (ovf_0),
        .ovf_1          (ovf_1),
        .busy           (busy)
    );

    // Reference model: lifetime commit/release counts per ring plus the
    // currently offered slot (offered, accepted by egress or not).
    int wc[2];
    int rc[2];
    bit m_ovf[2];
    bit m_offer;
    bit m_accepted;
    int m_ch;
    int m_slot;
    int m_last;

    int total  = 0;
    int passed = 0;
    bit auto_eg = 1'b0;
    int g_ch[$];
    int g_slot[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            wc[c] = 0;
            rc[c] = 0;
            m_ovf[c] = 1'b0;
        end
        m_offer = 1'b0;
        m_accepted = 1'b0;
        m_ch = 0;
        m_slot = 0;
        m_last = 1;
    endfunction

    function automatic void model_edge();
        bit ne[2];
        bit full[2];
        bit cm[2];
        cm[0] = wr_commit_0;
        cm[1] = wr_commit_1;
        for (int c = 0; c < 2; c++) begin
            ne[c]   = (wc[c] != rc[c]);
            full[c] = ((wc[c] - rc[c]) == DEPTH);
        end
        if (!m_offer) begin
            if (ne[0] || ne[1]) begin
                m_ch       = (ne[0] && ne[1]) ? (1 - m_last) : (ne[0] ? 0 : 1);
                m_slot     = rc[m_ch] % DEPTH;
                m_last     = m_ch;
                m_offer    = 1'b1;
                m_accepted = 1'b0;
            end
        end else if (!m_accepted) begin
            if (tx_ack) m_accepted = 1'b1;
        end else if (tx_done) begin
            rc[m_ch]++;
            m_offer = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            if (cm[c]) begin
                if (full[c]) m_ovf[c] = 1'b1;
                else wc[c]++;
            end
        end
    endfunction

    task automatic compare();
        chk("wr_ptr_0", int'(wr_ptr_0), wc[0] % PMOD);
        chk("wr_ptr_1", int'(wr_ptr_1), wc[1] % PMOD);
        chk("rd_ptr_0", int'(rd_ptr_0), rc[0] % PMOD);
        chk("rd_ptr_1", int'(rd_ptr_1), rc[1] % PMOD);
        chk("wr_greenflag_0", int'(wr_greenflag_0), int'((wc[0] - rc[0]) != DEPTH));
        chk("wr_greenflag_1", int'(wr_greenflag_1), int'((wc[1] - rc[1]) != DEPTH));
        chk("rd_greenflag_0", int'(rd_greenflag_0), int'(wc[0] != rc[0]));
        chk("rd_greenflag_1", int'(rd_greenflag_1), int'(wc[1] != rc[1]));
        chk("tx_req", int'(tx_req), int'(m_offer && !m_accepted));
        chk("busy", int'(busy), int'(m_offer));
        chk("tx_ch", int'(tx_ch), m_ch);
        chk("tx_slot", int'(tx_slot), m_slot);
        chk("ovf_0", int'(ovf_0), int'(m_ovf[0]));
        chk("ovf_1", int'(ovf_1), int'(m_ovf[1]));
    endtask

    task automatic step();
        if (tx_req && tx_ack) begin
            g_ch.push_back(int'(tx_ch));
            g_slot.push_back(int'(tx_slot));
        end
        @(posedge clk);
        model_edge();
        #1;
        compare();
        if (auto_eg) begin
            tx_ack  = tx_req;
            tx_done = busy && !tx_req;
        end
    endtask

    task automatic do_reset();
        #2;
        wr_commit_0 = 1'b0;
        wr_commit_1 = 1'b0;
        tx_ack = 1'b0;
        tx_done = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_tx_req", int'(tx_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tx_ch", int'(tx_ch), 0);
        chk("rst_tx_slot", int'(tx_slot), 0);
        chk("rst_ptrs", int'({wr_ptr_0, wr_ptr_1, rd_ptr_0, rd_ptr_1}), 0);
        chk("rst_wr_green", int'({wr_greenflag_0, wr_greenflag_1}), 3);
        chk("rst_rd_green", int'({rd_greenflag_0, rd_greenflag_1}), 0);
        chk("rst_ovf", int'({ovf_0, ovf_1}), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        bit drained;
        drained = 1'b0;
        auto_eg = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (wc[0] == rc[0] && wc[1] == rc[1] && !m_offer) begin
                drained = 1'b1;
                break;
            end
            step();
        end
        chk("drain_within_budget", int'(drained), 1);
        auto_eg = 1'b0;
        tx_ack = 1'b0;
        tx_done = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single commit on ch0, full handshake.
        wr_commit_0 = 1'b1; step(); wr_commit_0 = 1'b0;
        chk("t1_wr_ptr_0", int'(wr_ptr_0), 1);
        chk("t1_rd_green_0", int'(rd_greenflag_0), 1);
        chk("t1_no_req_yet", int'(tx_req), 0);
        step();
        chk("t1_req", int'(tx_req), 1);
        chk("t1_ch", int'(tx_ch), 0);
        chk("t1_slot", int'(tx_slot), 0);
        tx_ack = 1'b1; step(); tx_ack = 1'b0;
        chk("t1_xfer_busy", int'(busy), 1);
        chk("t1_xfer_req", int'(tx_req), 0);
        tx_done = 1'b1; step(); tx_done = 1'b0;
        chk("t1_rd_ptr_0", int'(rd_ptr_0), 1);
        chk("t1_empty", int'(rd_greenflag_0), 0);
        chk("t1_idle", int'(busy), 0);

        // Fill ch1 and overflow it.
        do_reset();
        wr_commit_1 = 1'b1;
        repeat (4) step();
        chk("t2_wr_ptr_1", int'(wr_ptr_1), 4);
        chk("t2_full", int'(wr_greenflag_1), 0);
        chk("t2_no_ovf", int'(ovf_1), 0);
        step();
        wr_commit_1 = 1'b0;
        chk("t2_wr_ptr_1_held", int'(wr_ptr_1), 4);
        chk("t2_ovf_1", int'(ovf_1), 1);
        drain();
        chk("t2_ovf_sticky", int'(ovf_1), 1);

        // Round-robin between two rings of two slots each.
        do_reset();
        wr_commit_0 = 1'b1; wr_commit_1 = 1'b1;
        repeat (2) step();
        wr_commit_0 = 1'b0; wr_commit_1 = 1'b0;
        g_ch.delete(); g_slot.delete();
        drain();
        chk("t3_grant_count", g_ch.size(), 4);
        if (g_ch.size() == 4) begin
            chk("t3_g0_ch", g_ch[0], 0); chk("t3_g0_slot", g_slot[0], 0);
            chk("t3_g1_ch", g_ch[1], 1); chk("t3_g1_slot", g_slot[1], 0);
            chk("t3_g2_ch", g_ch[2], 0); chk("t3_g2_slot", g_slot[2], 1);
            chk("t3_g3_ch", g_ch[3], 1); chk("t3_g3_slot", g_slot[3], 1);
        end

        // Nine commit/release pairs on ch0 across the pointer wrap.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wr_commit_0 = 1'b1; step(); wr_commit_0 = 1'b0;
            chk("t4_wr_ptr", int'(wr_ptr_0), (i + 1) % 8);
            g_ch.delete(); g_slot.delete();
            drain();
            chk("t4_grants", g_slot.size(), 1);
            if (g_slot.size() == 1) chk("t4_slot", g_slot[0], i % 4);
            chk("t4_rd_ptr", int'(rd_ptr_0), (i + 1) % 8);
            chk("t4_empty", int'(rd_greenflag_0), 0);
            chk("t4_not_full", int'(wr_greenflag_0), 1);
        end

        // Commit into a full ring in the same cycle as a release.
        do_reset();
        wr_commit_0 = 1'b1;
        repeat (4) step();
        wr_commit_0 = 1'b0;
        chk("t5_full", int'(wr_greenflag_0), 0);
        tx_ack = 1'b1; step(); tx_ack = 1'b0;
        wr_commit_0 = 1'b1; tx_done = 1'b1; step();
        wr_commit_0 = 1'b0; tx_done = 1'b0;
        chk("t5_rd_ptr_0", int'(rd_ptr_0), 1);
        chk("t5_wr_ptr_0", int'(wr_ptr_0), 4);
        chk("t5_ovf_0", int'(ovf_0), 1);

        // Reset asserted mid-transfer, then a stray done.
        step();
        tx_ack = 1'b1; step(); tx_ack = 1'b0;
        chk("t6_in_xfer", int'(busy), 1);
        do_reset();
        tx_done = 1'b1; step(); tx_done = 1'b0;
        chk("t6_rd_ptr_0", int'(rd_ptr_0), 0);
        chk("t6_idle", int'(busy), 0);

        // Random traffic including stray ack/done pulses.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            wr_commit_0 = ($urandom_range(0, 2) == 0);
            wr_commit_1 = ($urandom_range(0, 2) == 0);
            tx_ack      = ($urandom_range(0, 1) == 1);
            tx_done     = ($urandom_range(0, 1) == 1);
            step();
        end
        wr_commit_0 = 1'b0; wr_commit_1 = 1'b0;
        tx_ack = 1'b0; tx_done = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/ring_sched.md
# ring_sched

Slot-ring controller and egress scheduler for the two-channel packet buffer. It owns the write/read tribit pointers of two 4-slot rings (channel 0, channel 1) and derives each ring's not-full / not-empty flags. It arbitrates round-robin between non-empty rings and sequences one slot at a time to the single egress transmitter via a req/ack/done handshake. It sits between the ingress slot writers and the egress engine.

## Interface
- SLOT_AW, 2, slot address width; pointers are SLOT_AW+1 bits (MSB = wrap bit); ring depth 2**SLOT_AW
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- wr_commit_0 / wr_commit_1  in  1  one-cycle pulse: writer has filled slot wr_ptr_x[SLOT_AW-1:0]
- wr_ptr_0 / wr_ptr_1  out  SLOT_AW+1  registered write pointer; low bits = slot being filled
- wr_greenflag_0 / wr_greenflag_1  out  1  ring not full
- rd_ptr_0 / rd_ptr_1  out  SLOT_AW+1  registered read pointer
- rd_greenflag_0 / rd_greenflag_1  out  1  ring not empty
- tx_req  out  1  slot offered to egress
- tx_ch  out  1  channel of offered slot
- tx_slot  out  SLOT_AW  slot address of offered slot
- tx_ack  in  1  egress accepts offer
- tx_done  in  1  one-cycle pulse: egress finished reading slot
- ovf_0 / ovf_1  out  1  sticky: commit received while ring full
- busy  out  1  high in REQ or XFER

## Operation
- Flags per channel, combinational from registered pointers: not_full = !((w[MSB]!=r[MSB]) && (w[low]==r[low])); not_empty = (w != r).
- wr_commit_x with wr_greenflag_x=1: wr_ptr_x += 1 mod 2**(SLOT_AW+1). With wr_greenflag_x=0: pointer unchanged, ovf_x set (cleared only by reset).
- FSM states: IDLE, REQ, XFER.
- IDLE: if any rd_greenflag set, pick channel: if both set, pick channel != last_ch; else the set one. Register tx_ch, tx_slot = rd_ptr_ch[low], update last_ch -> REQ. Else stay.
- REQ: tx_req=1, tx_ch/tx_slot stable. tx_ack=1 -> XFER.
- XFER: tx_done=1 -> rd_ptr_ch += 1 (same edge), -> IDLE.
- tx_ack outside REQ and tx_done outside XFER ignored; tx_ack and tx_done in the same REQ cycle: only ack takes effect.
- Simultaneous commit on channel x and release on channel x: both pointers update on the same edge; full test uses pre-edge pointers, so commit on a full ring is dropped (ovf set) even if a release occurs that cycle.
- Wrap-around: low bits wrap (2**SLOT_AW-1)->0 and toggle MSB.

## Timing
- Reset values: all pointers 0, wr_greenflag_x=1, rd_greenflag_x=0, tx_req=0, tx_ch=0, tx_slot=0, ovf_x=0, busy=0, state IDLE, last_ch=1 (channel 0 wins first tie).
- Reset is asynchronous: tx_req drops immediately on rst_n low, mid-transfer slot is abandoned (not released).
- Commit at edge N -> pointer/flags valid after edge N; rd_greenflag visible to arbiter in cycle N+1.
- IDLE sees not-empty in cycle N -> tx_req high cycle N+1. Ack in N+1 -> XFER N+2. Done in N+2 -> rd_ptr advanced and IDLE in N+3 -> next tx_req N+4. Peak: one slot per 3 cycles.
- tx_req, tx_ch, tx_slot, busy are registered (no combinational path from inputs).

## Structure
- Shared package: state enum (IDLE/REQ/XFER), SLOT_AW default, PTR_W = SLOT_AW+1.
- Sub-module ring_ptr: one channel's wr/rd pointer registers, increment enables, flags, ovf; instantiated twice. Top holds FSM, round-robin, handshake.

## Test plan
- Reset, commit ch0 once -> wr_ptr_0=1, rd_greenflag_0=1; tx_req cycle+2 with tx_ch=0, tx_slot=0; ack, done -> rd_ptr_0=1, flags empty.
- Four commits ch1, no egress -> wr_ptr_1=4 (100b), wr_greenflag_1=0; fifth commit -> wr_ptr_1 unchanged, ovf_1=1.
- Both rings hold 2 slots, egress always acks/dones immediately -> grant order ch0,ch1,ch0,ch1 with tx_slot 0,0,1,1.
- 9 commit/release pairs on ch0 -> pointers wrap 7->0, tx_slot sequence 0,1,2,3,0,..., flags correct at each wrap.
- Ring ch0 full, commit and tx_done same cycle -> rd_ptr_0 advances, wr_ptr_0 unchanged, ovf_0=1.
- rst_n low during XFER -> tx_req/busy 0 immediately, all pointers 0; post-reset tx_done ignored.
